ahb_req_arbiter: RTL
====================

AHB_REQ_ARBITER -- requirements
Module: ahb_req_arbiter

Interface
REQ-001 Parameter TIMEOUT, 255, number of WAIT cycles without m_ready before abort (1..255).
REQ-002 HCLK  in  1  clock; all state changes on rising edge.
REQ-003 HRESETn  in  1  reset, asynchronous, active-low.
REQ-004 ic_req / dc_req / pe_req  in  1 each  level request from I-cache / D-cache / peripheral bridge; held until matching done.
REQ-005 ic_addr / dc_addr / pe_addr  in  32 each  word address of request.
REQ-006 dc_write / pe_write  in  1 each  1 = write; I-cache is read-only.
REQ-007 dc_wdata / pe_wdata  in  32 each  write data.
REQ-008 ic_ready / dc_ready / pe_ready  out  1 each  per-beat strobe; rdata valid when high.
REQ-009 ic_done / dc_done / pe_done  out  1 each  one-cycle completion pulse.
REQ-010 rdata  out  32  read data shared by all requesters (= m_rdata).
REQ-011 err  out  1  qualifies a done pulse as timeout abort.
REQ-012 m_addr / m_write / m_wdata  out  32/1/32  command to AHB master port.
REQ-013 m_transfer  out  3  0 none, 1 I-cache INCR8 read, 2 D-cache single, 3 peripheral single.
REQ-014 m_rdata / m_ready  in  32/1  read data and beat-accept from AHB master.

Function
REQ-015 States: IDLE, ISSUE, WAIT, DONE.
REQ-016 IDLE: if any req, select winner by round-robin, register grant, addr, write, wdata, go ISSUE; else stay.
REQ-017 Round-robin order I, D, P; pointer starts after last granted requester; reset pointer = P (first order I, D, P).
REQ-018 ISSUE (exactly 1 cycle): drive m_transfer = code of winner, m_addr/m_write/m_wdata from registers; go WAIT.
REQ-019 m_transfer = 0 in every state except ISSUE; m_addr/m_write/m_wdata held stable from ISSUE through DONE.
REQ-020 WAIT: each cycle m_ready = 1 drives granted X_ready = 1 combinationally, increments 3-bit beat counter.
REQ-021 Burst length: 8 beats for I-cache, 1 beat for D-cache/peripheral (reads and writes).
REQ-022 Final beat accepted -> DONE; err = 0.
REQ-023 Timeout counter (8-bit) clears on every m_ready and on ISSUE; reaching TIMEOUT in WAIT -> DONE with err = 1.
REQ-024 DONE (1 cycle): granted X_done = 1, err as latched; requests not evaluated; go IDLE.
REQ-025 Non-granted X_ready / X_done always 0; ready never asserted outside WAIT.
REQ-026 Request withdrawn mid-transaction: transaction still completes; done still pulsed.
REQ-027 Simultaneous requests: exactly one grant; losers wait, no starvation (each served within 3 transactions).
REQ-028 Requester re-asserting req in cycle after done is eligible in that IDLE cycle.

Reset
REQ-029 Reset: state IDLE, all ready/done/err 0, m_transfer 0, m_addr/m_wdata 0, m_write 0, counters 0, RR pointer = P.
REQ-030 Reset mid-transaction aborts immediately; no done pulse is generated.

Structure
REQ-031 Shared package holds transfer codes (NONE, ICACHE, DCACHE, PERIPH), state encoding, burst length constant 8.
REQ-032 Round-robin selection is sub-module rr_arbiter3 (3 requests, pointer in, one-hot grant out).

Verification
REQ-033 dc_req read, addr 0x1000, m_ready after 2 cycles -> m_transfer = 2 for one cycle, dc_ready once, dc_done next cycle, err 0.
REQ-034 ic_req addr 0x0, m_ready 8 consecutive cycles -> m_transfer = 1 once, 8 ic_ready pulses, ic_done after 8th.
REQ-035 ic_req, dc_req, pe_req all asserted from reset, held -> grant order I, D, P, then I again.
REQ-036 pe_req write, addr 0x4000_0000, wdata 0xDEADBEEF -> m_write = 1, m_wdata = 0xDEADBEEF stable through DONE, pe_done once.
REQ-037 dc_req, m_ready never asserted, TIMEOUT = 16 -> dc_done with err = 1 after 16 WAIT cycles, return to IDLE.
REQ-038 HRESETn low during I-cache beat 4 -> outputs at reset values immediately, no ic_done, fresh grant after release.

Source files
------------

// File: rtl/ahb_req_arbiter_pkg.sv
// Shared types and constants for the AHB request arbiter: transfer codes, FSM states,
// burst length and requester indices.
package ahb_req_arbiter_pkg;

  typedef enum logic [2:0] {
    XferNone   = 3'd0,
    XferIcache = 3'd1,
    XferDcache = 3'd2,
    XferPeriph = 3'd3
  } xfer_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

  localparam int unsigned BurstLen = 8;

  // Requester indices; also the bit positions in grant vectors.
  localparam logic [1:0] IdxI = 2'd0;
  localparam logic [1:0] IdxD = 2'd1;
  localparam logic [1:0] IdxP = 2'd2;

  function automatic xfer_e xfer_code(input logic [2:0] grant);
    xfer_e code;
    code = XferNone;
    unique case (1'b1)
      grant[0]: code = XferIcache;
      grant[1]: code = XferDcache;
      grant[2]: code = XferPeriph;
      default:  code = XferNone;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/ahb_req_arbiter_if.sv
// Requester-side and AHB-master-side signals of the arbiter. The arbiter uses the slave
// view; the environment (requesters plus AHB master port) uses the master view.
interface ahb_req_arbiter_if;

  logic        ic_req;
  logic        dc_req;
  logic        pe_req;
  logic [31:0] ic_addr;
  logic [31:0] dc_addr;
  logic [31:0] pe_addr;
  logic        dc_write;
  logic        pe_write;
  logic [31:0] dc_wdata;
  logic [31:0] pe_wdata;
  logic        ic_ready;
  logic        dc_ready;
  logic        pe_ready;
  logic        ic_done;
  logic        dc_done;
  logic        pe_done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] m_addr;
  logic        m_write;
  logic [31:0] m_wdata;
  logic [2:0]  m_transfer;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport slave (
    input  ic_req, dc_req, pe_req, ic_addr, dc_addr, pe_addr,
    input  dc_write, pe_write, dc_wdata, pe_wdata, m_rdata, m_ready,
    output ic_ready, dc_ready, pe_ready, ic_done, dc_done, pe_done,
    output rdata, err, m_addr, m_write, m_wdata, m_transfer
  );

  modport master (
    output ic_req, dc_req, pe_req, ic_addr, dc_addr, pe_addr,
    output dc_write, pe_write, dc_wdata, pe_wdata, m_rdata, m_ready,
    input  ic_ready, dc_ready, pe_ready, ic_done, dc_done, pe_done,
    input  rdata, err, m_addr, m_write, m_wdata, m_transfer
  );

endinterface

// File: rtl/ahb_req_arbiter_rr_arbiter3.sv
// Three-way round-robin selector: search starts at the requester after ptr (the last
// granted one) and wraps; grant is one-hot or zero when nothing requests.
module rr_arbiter3
  import ahb_req_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] grant
);

  always_comb begin
    grant = 3'b000;
    case (ptr)
      IdxI: begin
        if      (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
      end
      IdxD: begin
        if      (req[2]) grant = 3'b100;
        else if (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
      end
      default: begin
        if      (req[0]) grant = 3'b001;
        else if (req[1]) grant = 3'b010;
        else if (req[2]) grant = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/ahb_req_arbiter.sv
// Arbitrates I-cache, D-cache and peripheral-bridge requests onto one AHB master port,
// one transaction at a time, with a WAIT-state timeout that aborts with err.
module ahb_req_arbiter
  import ahb_req_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_req_arbiter_if.slave bus
);

  localparam logic [7:0] TmoLast   = 8'(TIMEOUT - 1);
  localparam logic [2:0] BeatLastI = 3'(BurstLen - 1);

  state_e      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [2:0]  beat_q, beat_d;
  logic [7:0]  tmo_q, tmo_d;

  logic [2:0]  req_vec;
  logic [2:0]  rr_grant;
  logic [2:0]  ready_v;
  logic [2:0]  done_v;
  logic        last_beat;
  xfer_e       xfer;

  assign req_vec = {bus.pe_req, bus.dc_req, bus.ic_req};

  rr_arbiter3 u_rr (
    .req  (req_vec),
    .ptr  (ptr_q),
    .grant(rr_grant)
  );

  // Only the I-cache bursts; every other transfer is a single beat.
  assign last_beat = grant_q[0] ? (beat_q == BeatLastI) : 1'b1;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    err_d   = err_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    ready_v = 3'b000;
    done_v  = 3'b000;
    xfer    = XferNone;
    case (state_q)
      StIdle: begin
        if (|req_vec) begin
          grant_d = rr_grant;
          state_d = StIssue;
          if (rr_grant[0]) begin
            ptr_d   = IdxI;
            addr_d  = bus.ic_addr;
            write_d = 1'b0;
            wdata_d = '0;
          end else if (rr_grant[1]) begin
            ptr_d   = IdxD;
            addr_d  = bus.dc_addr;
            write_d = bus.dc_write;
            wdata_d = bus.dc_wdata;
          end else begin
            ptr_d   = IdxP;
            addr_d  = bus.pe_addr;
            write_d = bus.pe_write;
            wdata_d = bus.pe_wdata;
          end
        end
      end
      StIssue: begin
        xfer    = xfer_code(grant_q);
        beat_d  = '0;
        tmo_d   = '0;
        err_d   = 1'b0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.m_ready) begin
          ready_v = grant_q;
          beat_d  = beat_q + 3'd1;
          tmo_d   = '0;
          if (last_beat) begin
            state_d = StDone;
            err_d   = 1'b0;
          end
        end else if (tmo_q == TmoLast) begin
          state_d = StDone;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      StDone: begin
        done_v  = grant_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= StIdle;
      grant_q <= '0;
      ptr_q   <= IdxP;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      beat_q  <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      err_q   <= err_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.ic_ready   = ready_v[0];
  assign bus.dc_ready   = ready_v[1];
  assign bus.pe_ready   = ready_v[2];
  assign bus.ic_done    = done_v[0];
  assign bus.dc_done    = done_v[1];
  assign bus.pe_done    = done_v[2];
  assign bus.err        = (state_q == StDone) & err_q;
  assign bus.rdata      = bus.m_rdata;
  assign bus.m_transfer = xfer;
  assign bus.m_addr     = addr_q;
  assign bus.m_write    = write_q;
  assign bus.m_wdata    = wdata_q;

endmodule
